spi_master_nch: RTL and testbench

Parametrised SPI master: the next generation of the two-slave SPI top. It supports a configurable frame width, N active-low slave selects, all four SPI modes (CPOL/CPHA) and a programmable SCLK divider. A host-side start/busy/done handshake drives it, and it sits between system control logic and the off-chip SPI pins. One transfer is a full-duplex frame of DATA_W bits to the one slave selected per transfer.

---
 rtl/spi_master_nch.sv | 183 ++++++++++++++++++
 tb/tb_spi_master_nch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_nch.sv
// rtl/spi_master_nch.sv - parametrised SPI master, N slave selects, CPOL/CPHA, SCLK divider; SPI_LSB_FIRST_EN selects LSB-first frames
module spi_master_nch #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  slave,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int ECNT_W = $clog2(2 * DATA_W + 1);
  localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * DATA_W);
  localparam logic [ECNT_W-1:0] PREV_EDGE = ECNT_W'(2 * DATA_W - 1);
  localparam logic [SEL_W:0]    NUM_SS_L  = (SEL_W + 1)'(NUM_SS);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t              state_q;
  logic                cpol_q;
  logic                cpha_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [ECNT_W-1:0]   ecnt_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_sr_q;
  logic [DATA_W-1:0]   rx_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                sclk_q;
  logic                mosi_q;
  logic [NUM_SS-1:0]   ss_n_q;

  logic                half_done_d;
  logic                shift_edge_d;
  logic                last_edge_d;
  logic                do_edge_d;
  logic                slave_ok_d;
  logic [NUM_SS-1:0]   ss_sel_d;
  logic                tx_bit_d;
  logic [DATA_W-1:0]   tx_shift_d;
  logic                load_bit_d;
  logic [DATA_W-1:0]   load_shift_d;
  logic [DATA_W-1:0]   rx_shift_d;

  // Edge scheduling, slave decode and bit-order dependent shift values
  always_comb begin
    half_done_d  = (cnt_q == div_q);
    // odd edge numbers are leading; CPHA=1 drives on leading, CPHA=0 drives on trailing
    shift_edge_d = ecnt_q[0] ? ~cpha_q : cpha_q;
    // the final trailing edge must not shift, so mosi keeps the last frame bit
    last_edge_d  = (ecnt_q == PREV_EDGE);
    do_edge_d    = half_done_d &&
                   ((state_q == S_SETUP) || ((state_q == S_XFER) && (ecnt_q != LAST_EDGE)));
    slave_ok_d   = ({1'b0, slave} < NUM_SS_L);
    ss_sel_d     = ~(NUM_SS'(1) << slave);
`ifdef SPI_LSB_FIRST_EN
    tx_bit_d     = tx_q[0];
    tx_shift_d   = tx_q >> 1;
    load_bit_d   = tx_data[0];
    load_shift_d = tx_data >> 1;
    rx_shift_d   = {miso, rx_sr_q[DATA_W-1:1]};
`else
    tx_bit_d     = tx_q[DATA_W-1];
    tx_shift_d   = tx_q << 1;
    load_bit_d   = tx_data[DATA_W-1];
    load_shift_d = tx_data << 1;
    rx_shift_d   = {rx_sr_q[DATA_W-2:0], miso};
`endif
  end

  // Transfer FSM with registered SPI pins and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      tx_q    <= '0;
      rx_sr_q <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (state_q != S_IDLE) begin
        cnt_q <= half_done_d ? '0 : cnt_q + DIV_W'(1);
      end

      if (do_edge_d) begin
        sclk_q <= ~sclk_q;
        ecnt_q <= ecnt_q + ECNT_W'(1);
        if (shift_edge_d && !last_edge_d) begin
          mosi_q <= tx_bit_d;
          tx_q   <= tx_shift_d;
        end
        if (!shift_edge_d) begin
          rx_sr_q <= rx_shift_d;
        end
      end

      case (state_q)
        S_IDLE: begin
          // the done cycle itself still counts as the tail of the previous transfer
          if (start && !done_q) begin
            if (slave_ok_d) begin
              cpol_q  <= mode[1];
              cpha_q  <= mode[0];
              div_q   <= clk_div;
              cnt_q   <= '0;
              ecnt_q  <= '0;
              rx_sr_q <= '0;
              busy_q  <= 1'b1;
              ss_n_q  <= ss_sel_d;
              sclk_q  <= mode[1];
              if (!mode[0]) begin
                mosi_q <= load_bit_d;
                tx_q   <= load_shift_d;
              end else begin
                tx_q   <= tx_data;
              end
              state_q <= S_SETUP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (half_done_d) begin
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (half_done_d && (ecnt_q == LAST_EDGE)) begin
            sclk_q  <= cpol_q;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (half_done_d) begin
            ss_n_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rx_q    <= rx_sr_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_master_nch.sv
// tb/tb_spi_master_nch.sv - scoreboard bench for spi_master_nch
module tb_spi_master_nch;

  typedef struct {
    int         inst;
    bit         is_err;
    logic [7:0] rx;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       loopback = 1'b1;
  logic       slave_bit = 1'b0;
  logic       slave_cpol = 1'b0;
  logic       miso0;
  logic [1:0] slave = 2'd0;
  logic [1:0] slave1 = 2'd0;
  logic [1:0] mode = 2'd0;
  logic [7:0] tx_data = 8'd0;
  logic [7:0] clk_div = 8'd0;
  logic [7:0] slave_sr = 8'd0;

  logic       busy0, done0, err0, sclk0, mosi0;
  logic       busy1, done1, err1, sclk1, mosi1;
  logic [7:0] rx0, rx1;
  logic [3:0] ss_n0;
  logic [2:0] ss_n1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt0 = 0;

`ifdef SPI_LSB_FIRST_EN
  localparam logic [7:0] MOSI_01 = 8'h80;
`else
  localparam logic [7:0] MOSI_01 = 8'h01;
`endif

  assign miso0 = loopback ? mosi0 : slave_bit;

  spi_master_nch #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .slave(slave), .tx_data(tx_data),
    .mode(mode), .clk_div(clk_div), .busy(busy0), .done(done0), .err(err0),
    .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .miso(miso0), .ss_n(ss_n0)
  );

  spi_master_nch #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .slave(slave1), .tx_data(tx_data),
    .mode(mode), .clk_div(clk_div), .busy(busy1), .done(done1), .err(err1),
    .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .ss_n(ss_n1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // bench slave: presents its next bit on every leading edge
  always @(sclk0) begin
    if (!loopback && (sclk0 !== slave_cpol)) begin
      slave_bit = slave_sr[7];
      slave_sr  = {slave_sr[6:0], 1'b0};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int inst, input bit is_err, input logic [7:0] rx, input int lat);
    exp_t e;
    e.inst   = inst;
    e.is_err = is_err;
    e.rx     = rx;
    e.cyc    = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic handle(input int inst, input bit is_err, input logic [7:0] rx);
    exp_t e;
    chk("sb_event_expected", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_inst", inst, e.inst);
      chk("sb_kind", is_err, e.is_err);
      chk("sb_cycle", cyc, e.cyc);
      if (!is_err) chk("sb_rx", rx, e.rx);
    end
  endtask

  // monitor: every done/err pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (done0 === 1'b1) done_cnt0++;
    if ((done0 === 1'b1) || (err0 === 1'b1)) handle(0, err0, rx0);
    if ((done1 === 1'b1) || (err1 === 1'b1)) handle(1, err1, rx1);
  end

  task automatic drive(input logic [1:0] sl, input logic [7:0] d, input logic [1:0] md,
                       input logic [7:0] dv);
    slave      = sl;
    tx_data    = d;
    mode       = md;
    clk_div    = dv;
    slave_cpol = md[1];
    start      = 1'b1;
  endtask

  task automatic run_xfer(input string nm, input logic [1:0] sl, input logic [7:0] d,
                          input logic [1:0] md, input logic [7:0] dv, input logic lb,
                          input logic [7:0] sw, input logic [3:0] exp_ss,
                          input logic [7:0] exp_mosi, input logic [7:0] exp_rx);
    int h, last, edges, rises, bad_ss, bad_int;
    logic ps;
    logic [7:0] mw;
    h = int'(dv) + 1;
    edges = 0; rises = 0; bad_ss = 0; bad_int = 0; mw = 8'h00;
    @(negedge clk);
    loopback  = lb;
    slave_sr  = sw;
    slave_bit = 1'b0;
    drive(sl, d, md, dv);
    push_exp(0, 0, exp_rx, 18 * h);
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_start"}, busy0, 1);
    chk({nm, "_ss_start"}, ss_n0, exp_ss);
    chk({nm, "_sclk_setup"}, sclk0, md[1]);
    ps = sclk0;
    last = cyc;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!busy0) break;
      if (ss_n0 !== exp_ss) bad_ss++;
      if (sclk0 !== ps) begin
        edges++;
        if (sclk0) rises++;
        if (cyc - last != h) bad_int++;
        last = cyc;
        if ((sclk0 !== md[1]) != md[0]) mw = {mw[6:0], mosi0};
        ps = sclk0;
      end
    end
    chk({nm, "_finished"}, busy0, 0);
    chk({nm, "_edges"}, edges, 16);
    chk({nm, "_rises"}, rises, 8);
    chk({nm, "_ss_hold"}, bad_ss, 0);
    chk({nm, "_half_period"}, bad_int, 0);
    chk({nm, "_mosi_bits"}, mw, exp_mosi);
    chk({nm, "_sclk_idle"}, sclk0, md[1]);
    chk({nm, "_ss_release"}, ss_n0, 4'hF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, edges;
    logic ps;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_rx", rx0, 8'h00);
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_ss", ss_n0, 4'hF);
    chk("rst_ss1", ss_n1, 3'h7);
    rst = 1'b0;

    run_xfer("m0_a5", 2'd1, 8'hA5, 2'b00, 8'd0, 1'b1, 8'h00, 4'b1101, 8'hA5, 8'hA5);
    run_xfer("m3_3c", 2'd0, 8'h3C, 2'b11, 8'd2, 1'b0, 8'hC3, 4'b1110, 8'h3C, 8'hC3);

    // start while busy is ignored; start in the done cycle is ignored, the next is taken
    @(negedge clk);
    loopback = 1'b1;
    base = done_cnt0;
    drive(2'd0, 8'h96, 2'b00, 8'd1);
    push_exp(0, 0, 8'h96, 36);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy0, 1);
    repeat (6) @(negedge clk);
    drive(2'd0, 8'hFF, 2'b00, 8'd1);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done0) break;
    end
    chk("b2b_first_done", done0, 1);
    drive(2'd0, 8'h33, 2'b00, 8'd1);
    @(negedge clk);
    push_exp(0, 0, 8'h33, 36);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", busy0, 1);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy0) break;
    end
    @(negedge clk);
    chk("b2b_done_count", done_cnt0 - base, 2);

    // three-slave instance: out-of-range index is rejected, valid index works
    @(negedge clk);
    slave1 = 2'd3;
    start1 = 1'b1;
    push_exp(1, 1, 8'h00, 0);
    @(negedge clk);
    start1 = 1'b0;
    edges = 0;
    for (int n = 0; n < 6; n++) begin
      if ((ss_n1 !== 3'b111) || (busy1 !== 1'b0)) edges++;
      @(negedge clk);
    end
    chk("err_idle_outputs", edges, 0);
    slave1  = 2'd2;
    tx_data = 8'h69;
    mode    = 2'b00;
    clk_div = 8'd0;
    start1  = 1'b1;
    push_exp(1, 0, 8'h69, 18);
    @(negedge clk);
    start1 = 1'b0;
    chk("u1_ss", ss_n1, 3'b011);
    chk("u1_busy", busy1, 1);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    chk("u1_finished", busy1, 0);

    // reset in the middle of a mode-1 transfer
    chk("pre_rst_rx", rx0, 8'h33);
    @(negedge clk);
    loopback = 1'b1;
    drive(2'd3, 8'hE7, 2'b01, 8'd0);
    @(negedge clk);
    start = 1'b0;
    ps = sclk0;
    edges = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sclk0 !== ps) begin
        edges++;
        ps = sclk0;
      end
      if (edges == 8) break;
    end
    chk("mid_rst_edges", edges, 8);
    chk("mid_rst_ss_active", ss_n0, 4'b0111);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ss", ss_n0, 4'hF);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_sclk", sclk0, 0);
    chk("mid_rst_rx", rx0, 8'h00);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_mosi", mosi0, 0);
    rst = 1'b0;

    run_xfer("m1_5a", 2'd0, 8'h5A, 2'b01, 8'd0, 1'b1, 8'h00, 4'b1110, 8'h5A, 8'h5A);
    run_xfer("m0_01", 2'd2, 8'h01, 2'b00, 8'd1, 1'b1, 8'h00, 4'b1011, MOSI_01, 8'h01);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
